// File: rtl/vector_register_file.sv
// Vector core register file: DATA_W-bit entries, two combinational read ports,
// one synchronous write port, optional hardwired-zero entry 0.
module vector_register_file #(
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned ADDR_W  = 5,
  parameter bit          ZERO_R0 = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we3,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  input  logic [ADDR_W-1:0] a3,
  input  logic [DATA_W-1:0] wd3,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] entries [DEPTH];
  logic              write_ok;

  // Writes aimed at the hardwired-zero entry are dropped at the port.
  assign write_ok = we3 && !(ZERO_R0 && (a3 == '0));

  // NOTE: every entry sits on the async reset because a reset must leave the
  // file reading zero immediately; this keeps it a flop array, not an SRAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        // NOTE: non-blocking assignments for all state so the reads seen by
        // other processes in this time step still return the pre-edge value.
        entries[i] <= '0;
      end
    end else if (write_ok) begin
      entries[a3] <= wd3;
    end
  end

  // No write-to-read bypass: reads always see the stored value.
  always_comb begin
    rd1 = entries[a1];
    if (ZERO_R0 && (a1 == '0)) begin
      rd1 = '0;
    end
  end

  always_comb begin
    rd2 = entries[a2];
    if (ZERO_R0 && (a2 == '0)) begin
      rd2 = '0;
    end
  end

endmodule

// File: tb/tb_vector_register_file.sv
// Self-checking bench for vector_register_file: directed steps plus a randomized
// phase checked against an array model of the register file.
module tb_vector_register_file;

  localparam int DATA_W = 128;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              we3;
  logic [ADDR_W-1:0] a1, a2, a3;
  logic [DATA_W-1:0] wd3;
  logic [DATA_W-1:0] rd1, rd2;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] ref_mem [DEPTH];

  vector_register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_R0(1'b1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .we3  (we3),
    .a1   (a1),
    .a2   (a2),
    .a3   (a3),
    .wd3  (wd3),
    .rd1  (rd1),
    .rd2  (rd2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] model_read(input int addr);
    return (addr == 0) ? '0 : ref_mem[addr];
  endfunction

  function automatic logic [DATA_W-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  // One clock cycle: drive at negedge, check old data before the edge,
  // apply the write to the model at the edge, check new data after it.
  task automatic cycle(input string tag, input logic we, input int wa,
                       input logic [DATA_W-1:0] wd, input int ra1, input int ra2);
    @(negedge clk);
    we3 = we; a3 = ADDR_W'(wa); wd3 = wd; a1 = ADDR_W'(ra1); a2 = ADDR_W'(ra2);
    #1;
    check({tag, "_pre_rd1"}, rd1, model_read(ra1));
    check({tag, "_pre_rd2"}, rd2, model_read(ra2));
    @(posedge clk);
    if (we && wa != 0) ref_mem[wa] = wd;
    #1;
    check({tag, "_post_rd1"}, rd1, model_read(ra1));
    check({tag, "_post_rd2"}, rd2, model_read(ra2));
  endtask

  // Idle sweep of both read ports over every address (ports in opposite order).
  task automatic sweep(input string tag);
    we3 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      a1 = ADDR_W'(i);
      a2 = ADDR_W'(DEPTH - 1 - i);
      #1;
      check($sformatf("%s_rd1_a%0d", tag, i), rd1, model_read(i));
      check($sformatf("%s_rd2_a%0d", tag, DEPTH - 1 - i), rd2, model_read(DEPTH - 1 - i));
    end
  endtask

  initial begin
    logic [DATA_W-1:0] v;
    int wa;

    model_clear();
    rst_n = 1'b0; we3 = 1'b0; a1 = '0; a2 = '0; a3 = '0; wd3 = '0;
    #2;
    sweep("reset_init");
    @(negedge clk);
    rst_n = 1'b1;

    // Write then read on another port; unwritten entry reads zero.
    v = {4{32'hABCDE123}};
    cycle("wr5", 1'b1, 5, v, 0, 0);
    cycle("rd5", 1'b0, 0, '0, 5, 10);
    check("rd5_value", rd1, v);
    check("rd10_zero", rd2, '0);

    // Same-cycle read and write: old value before the edge, new after.
    cycle("wr7_rd7", 1'b1, 7, {4{32'h12345678}}, 7, 7);
    check("rd7_new", rd1, {4{32'h12345678}});

    // we3=0 leaves entry 1 alone; then write and read on both ports.
    cycle("nowr1", 1'b0, 1, '1, 1, 1);
    check("nowr1_zero", rd1, '0);
    v = 128'hABCDEFFF_ABCD1234_ABCD5678_ABCD9ABC;
    cycle("wr1", 1'b1, 1, v, 1, 1);
    check("wr1_rd1", rd1, v);
    check("wr1_rd2", rd2, v);

    // Entry 0 ignores writes; entry 31 is ordinary.
    cycle("wr0", 1'b1, 0, {4{32'hDEADBEEF}}, 0, 0);
    check("wr0_reads_zero", rd1, '0);
    v = rand128();
    cycle("wr31", 1'b1, 31, v, 0, 31);
    check("wr31_rd2", rd2, v);

    // Back-to-back writes to one address: last wins.
    cycle("b2b_a", 1'b1, 12, {4{32'h11111111}}, 12, 0);
    cycle("b2b_b", 1'b1, 12, {4{32'h22222222}}, 12, 0);
    check("b2b_last", rd1, {4{32'h22222222}});

    // Unique pattern per address, then a full aliasing sweep.
    for (int i = 0; i < DEPTH; i++) begin
      cycle($sformatf("pat%0d", i), 1'b1, i, {4{32'(i) | 32'hA5000000}}, i, DEPTH - 1 - i);
    end
    sweep("pattern");

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      cycle($sformatf("rnd%0d", n), 1'($urandom_range(0, 3) != 0),
            int'($urandom_range(0, DEPTH - 1)), rand128(),
            int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)));
    end

    // Mid-run asynchronous reset: outputs clear with no clock edge.
    @(negedge clk);
    a1 = 5'd31; a2 = 5'd12;
    we3 = 1'b1; a3 = 5'd9; wd3 = {4{32'h0BADF00D}};
    #1;
    rst_n = 1'b0;
    model_clear();
    #1;
    check("async_rst_rd1", rd1, '0);
    check("async_rst_rd2", rd2, '0);
    @(posedge clk);   // write attempted while held in reset
    #1;
    sweep("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sweep("after_release");

    // Writes work again after release.
    wa = int'($urandom_range(1, DEPTH - 1));
    v = rand128();
    cycle("post_rst_wr", 1'b1, wa, v, wa, 0);
    check("post_rst_value", rd1, v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
